// File: rtl/ir_pkg.sv
// Shared types and default timing windows for the NEC IR receive path.
// One tick is 281.25 us; all windows are inclusive.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE
    } ir_state_t;

    localparam int unsigned NEC_BITS = 32;

    localparam int unsigned DEF_LEAD_MARK_MIN  = 28;
    localparam int unsigned DEF_LEAD_MARK_MAX  = 36;
    localparam int unsigned DEF_LEAD_SPACE_MIN = 14;
    localparam int unsigned DEF_LEAD_SPACE_MAX = 18;
    localparam int unsigned DEF_BIT_MARK_MIN   = 1;
    localparam int unsigned DEF_BIT_MARK_MAX   = 3;
    localparam int unsigned DEF_ZERO_MIN       = 1;
    localparam int unsigned DEF_ZERO_MAX       = 3;
    localparam int unsigned DEF_ONE_MIN        = 5;
    localparam int unsigned DEF_ONE_MAX        = 7;
    localparam int unsigned DEF_TIMEOUT        = 40;

    function automatic logic in_window(
        input int unsigned v,
        input int unsigned lo,
        input int unsigned hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ir_edge_detect.sv
// Registers the synchronized IR level and flags rising/falling edges
// in the cycle where the new level first appears.
module ir_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ir,
    output logic o_rise,
    output logic o_fall
);

    logic ir_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ir_q <= 1'b0;
        end else begin
            ir_q <= i_ir;
        end
    end

    assign o_rise = i_ir & ~ir_q;
    assign o_fall = ~i_ir & ir_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC frame decoder: classifies mark/space widths from the tick counter
// and assembles 32-bit LSB-first frames into address/command pairs.
module ir_nec_decoder
    import ir_pkg::*;
#(
    parameter int unsigned N              = 6,
    parameter int unsigned LEAD_MARK_MIN  = DEF_LEAD_MARK_MIN,
    parameter int unsigned LEAD_MARK_MAX  = DEF_LEAD_MARK_MAX,
    parameter int unsigned LEAD_SPACE_MIN = DEF_LEAD_SPACE_MIN,
    parameter int unsigned LEAD_SPACE_MAX = DEF_LEAD_SPACE_MAX,
    parameter int unsigned BIT_MARK_MIN   = DEF_BIT_MARK_MIN,
    parameter int unsigned BIT_MARK_MAX   = DEF_BIT_MARK_MAX,
    parameter int unsigned ZERO_MIN       = DEF_ZERO_MIN,
    parameter int unsigned ZERO_MAX       = DEF_ZERO_MAX,
    parameter int unsigned ONE_MIN        = DEF_ONE_MIN,
    parameter int unsigned ONE_MAX        = DEF_ONE_MAX,
    parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ir,
    input  logic [N-1:0] i_count,
    output logic         o_count_clear,
    output logic [7:0]   o_addr,
    output logic [7:0]   o_cmd,
    output logic         o_valid,
    output logic         o_error
);

    ir_state_t   state;
    logic [31:0] sr;
    logic [5:0]  bit_cnt;
    logic [31:0] width;
    logic        rise;
    logic        fall;
    logic        edge_seen;
    logic        lead_mark_ok;
    logic        lead_space_ok;
    logic        bit_mark_ok;
    logic        zero_ok;
    logic        one_ok;
    logic        frame_ok;
    logic        timeout;

    ir_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ir    (i_ir),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    assign edge_seen = rise | fall;
    assign width     = 32'(i_count);

    assign lead_mark_ok  = in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX);
    assign lead_space_ok = in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
    assign bit_mark_ok   = in_window(width, BIT_MARK_MIN, BIT_MARK_MAX);
    assign zero_ok       = in_window(width, ZERO_MIN, ZERO_MAX);
    assign one_ok        = in_window(width, ONE_MIN, ONE_MAX);

    assign frame_ok = (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);

    // A level change always takes priority over a stale count.
    assign timeout = (state != S_IDLE) && !edge_seen && (width >= TIMEOUT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            sr            <= '0;
            bit_cnt       <= '0;
            o_addr        <= '0;
            o_cmd         <= '0;
            o_count_clear <= 1'b0;
            o_valid       <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_count_clear <= edge_seen;
            o_valid       <= 1'b0;
            o_error       <= 1'b0;
            if (timeout) begin
                state   <= S_IDLE;
                o_error <= 1'b1;
            end else if (edge_seen) begin
                unique case (state)
                    S_IDLE: begin
                        if (rise) state <= S_LEAD_MARK;
                    end
                    S_LEAD_MARK: begin
                        if (fall && lead_mark_ok) begin
                            state <= S_LEAD_SPACE;
                        end else begin
                            state   <= S_IDLE;
                            o_error <= 1'b1;
                        end
                    end
                    S_LEAD_SPACE: begin
                        if (rise && lead_space_ok) begin
                            state   <= S_BIT_MARK;
                            bit_cnt <= '0;
                        end else begin
                            state   <= S_IDLE;
                            o_error <= 1'b1;
                        end
                    end
                    S_BIT_MARK: begin
                        if (fall && bit_mark_ok) begin
                            if (bit_cnt == 6'(NEC_BITS)) begin
                                state <= S_IDLE;
                                if (frame_ok) begin
                                    o_addr  <= sr[7:0];
                                    o_cmd   <= sr[23:16];
                                    o_valid <= 1'b1;
                                end else begin
                                    o_error <= 1'b1;
                                end
                            end else begin
                                state <= S_BIT_SPACE;
                            end
                        end else begin
                            state   <= S_IDLE;
                            o_error <= 1'b1;
                        end
                    end
                    S_BIT_SPACE: begin
                        if (rise && (zero_ok || one_ok)) begin
                            sr      <= {one_ok, sr[31:1]};
                            bit_cnt <= bit_cnt + 6'd1;
                            state   <= S_BIT_MARK;
                        end else begin
                            state   <= S_IDLE;
                            o_error <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder; the bench drives i_count itself
// in place of sync_counter.
module tb_ir_nec_decoder;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         ir;
    logic [N-1:0] cnt;
    logic         clr;
    logic [7:0]   addr;
    logic [7:0]   cmd;
    logic         valid;
    logic         err;

    int vectors    = 0;
    int miscompares = 0;
    int n_valid    = 0;
    int n_error    = 0;
    int n_clear    = 0;
    int n_wide     = 0;
    int edges_sent = 0;
    logic prev_clr = 1'b0;
    logic cur_lvl;
    logic last_err;
    logic last_valid;
    logic [7:0] last_addr;
    int v0;
    int e0;

    ir_nec_decoder #(.N(N)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_ir          (ir),
        .i_count       (cnt),
        .o_count_clear (clr),
        .o_addr        (addr),
        .o_cmd         (cmd),
        .o_valid       (valid),
        .o_error       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            prev_clr <= 1'b0;
        end else begin
            prev_clr <= clr;
            if (valid) n_valid <= n_valid + 1;
            if (err) n_error <= n_error + 1;
            if (clr) n_clear <= n_clear + 1;
            if (clr && prev_clr) n_wide <= n_wide + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic send_edge(input logic lvl, input int w);
        @(negedge clk);
        ir = lvl;
        cnt = N'(w);
        cur_lvl = lvl;
        edges_sent++;
        @(posedge clk);
        #1;
        chk("clear_on", 32'(clr), 32'd1);
        last_err = err;
        last_valid = valid;
        last_addr = addr;
        @(negedge clk);
        cnt = '0;
        @(posedge clk);
        #1;
        chk("clear_off", 32'(clr), 32'd0);
    endtask

    task automatic send_header();
        if (cur_lvl) send_edge(1'b0, 3);
        send_edge(1'b1, 10);
        send_edge(1'b0, 32);
        send_edge(1'b1, 16);
    endtask

    task automatic send_bit(input logic b, input int zw, input int ow);
        send_edge(1'b0, 2);
        send_edge(1'b1, b ? ow : zw);
    endtask

    task automatic send_frame(input logic [31:0] word, input int zw,
                              input int ow);
        send_header();
        for (int i = 0; i < 32; i++) send_bit(word[i], zw, ow);
        send_edge(1'b0, 2);
    endtask

    function automatic logic [31:0] nec_word(input logic [7:0] a,
                                             input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    initial begin
        rst = 1'b1;
        ir = 1'b0;
        cnt = '0;
        cur_lvl = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_error", 32'(err), 32'h0);
        chk("rst_clear", 32'(clr), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // good frame
        v0 = n_valid; e0 = n_error;
        send_frame(nec_word(8'h5A, 8'h0C), 2, 6);
        chk("good_valid_pulse", 32'(last_valid), 32'd1);
        chk("good_addr_with_valid", 32'(last_addr), 32'h5A);
        settle();
        chk("good_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("good_error_cnt", 32'(n_error - e0), 32'd0);
        chk("good_addr", 32'(addr), 32'h5A);
        chk("good_cmd", 32'(cmd), 32'h0C);

        // bad command complement
        v0 = n_valid; e0 = n_error;
        send_frame({8'h00, 8'h0C, 8'hA5, 8'h5A}, 2, 6);
        chk("badc_error_pulse", 32'(last_err), 32'd1);
        settle();
        chk("badc_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("badc_error_cnt", 32'(n_error - e0), 32'd1);
        chk("badc_addr_kept", 32'(addr), 32'h5A);
        chk("badc_cmd_kept", 32'(cmd), 32'h0C);

        // leader mark too short, then recovery
        v0 = n_valid; e0 = n_error;
        send_edge(1'b1, 10);
        send_edge(1'b0, 20);
        chk("short_lead_error", 32'(last_err), 32'd1);
        send_frame(nec_word(8'h33, 8'hC4), 2, 6);
        settle();
        chk("recover_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("recover_error_cnt", 32'(n_error - e0), 32'd1);
        chk("recover_addr", 32'(addr), 32'h33);
        chk("recover_cmd", 32'(cmd), 32'hC4);

        // line stuck at space after bit 10
        e0 = n_error;
        send_header();
        for (int i = 0; i < 10; i++) send_bit(1'(i % 2), 2, 6);
        send_edge(1'b0, 2);
        for (int c = 30; c <= 40; c++) begin
            @(negedge clk);
            cnt = N'(c);
            @(posedge clk);
            #1;
            chk($sformatf("timeout_at_%0d", c), 32'(err),
                (c == 40) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        cnt = '0;
        @(posedge clk);
        #1;
        chk("timeout_one_cycle", 32'(err), 32'd0);
        settle();
        chk("timeout_error_cnt", 32'(n_error - e0), 32'd1);
        chk("timeout_addr_kept", 32'(addr), 32'h33);

        // space window boundaries
        v0 = n_valid;
        send_frame(nec_word(8'hA5, 8'h3C), 1, 5);
        settle();
        chk("bnd_lo_addr", 32'(addr), 32'hA5);
        chk("bnd_lo_cmd", 32'(cmd), 32'h3C);
        send_frame(nec_word(8'h96, 8'h69), 3, 7);
        settle();
        chk("bnd_hi_addr", 32'(addr), 32'h96);
        chk("bnd_hi_cmd", 32'(cmd), 32'h69);
        chk("bnd_valid_cnt", 32'(n_valid - v0), 32'd2);

        e0 = n_error;
        send_header();
        send_bit(1'b1, 2, 4);
        chk("space4_error", 32'(last_err), 32'd1);
        send_header();
        send_bit(1'b1, 2, 8);
        chk("space8_error", 32'(last_err), 32'd1);
        settle();
        chk("space_abort_cnt", 32'(n_error - e0), 32'd2);
        chk("space_abort_addr", 32'(addr), 32'h96);

        // reset in the middle of a frame
        v0 = n_valid; e0 = n_error;
        send_header();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 2, 6);
        @(negedge clk);
        rst = 1'b1;
        ir = 1'b0;
        cur_lvl = 1'b0;
        #1;
        chk("mrst_addr", 32'(addr), 32'h0);
        chk("mrst_cmd", 32'(cmd), 32'h0);
        chk("mrst_valid", 32'(valid), 32'h0);
        chk("mrst_error", 32'(err), 32'h0);
        chk("mrst_clear", 32'(clr), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();
        chk("mrst_no_strobe", 32'(n_valid - v0 + n_error - e0), 32'd0);
        send_frame(nec_word(8'h12, 8'h34), 2, 6);
        settle();
        chk("mrst_next_addr", 32'(addr), 32'h12);
        chk("mrst_next_cmd", 32'(cmd), 32'h34);
        chk("mrst_next_valid", 32'(n_valid - v0), 32'd1);
        chk("mrst_next_error", 32'(n_error - e0), 32'd0);

        chk("clear_per_edge", 32'(n_clear), 32'(edges_sent));
        chk("clear_width", 32'(n_wide), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ir_nec_decoder.md
# ir_nec_decoder

Pulse-width decoder for the VCR remote receive path. It sits directly downstream of `sync_counter`: it watches the synchronized IR line, and on each level change it reads the tick count that `sync_counter` accumulated and clears that count through `sync_counter`'s `i_reset_cond`. Classified mark/space widths drive an NEC-frame state machine. Each good frame produces an address/command pair with a one-cycle valid strobe; any malformed frame produces a one-cycle error strobe.

## Interface
Parameters:
- `N`, 6: width of the tick count; matches `sync_counter` `N`.
- `LEAD_MARK_MIN`/`LEAD_MARK_MAX`, 28/36: leader mark window in ticks (1 tick = 281.25 us).
- `LEAD_SPACE_MIN`/`LEAD_SPACE_MAX`, 14/18: leader space window.
- `BIT_MARK_MIN`/`BIT_MARK_MAX`, 1/3: data and stop mark window.
- `ZERO_MIN`/`ZERO_MAX`, 1/3: space window for a logic 0.
- `ONE_MIN`/`ONE_MAX`, 5/7: space window for a logic 1.
- `TIMEOUT`, 40: abort threshold in ticks; must be < 2^N − 1.

Ports:
- `i_clk` in 1: system clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_ir` in 1: IR level, already synchronized to `i_clk`; 1 = mark (carrier present).
- `i_count` in N: tick count from `sync_counter` `o_count`.
- `o_count_clear` out 1: one-cycle pulse, wired to `sync_counter` `i_reset_cond`.
- `o_addr` out 8: address of the last good frame.
- `o_cmd` out 8: command of the last good frame.
- `o_valid` out 1: one-cycle pulse when `o_addr`/`o_cmd` update.
- `o_error` out 1: one-cycle pulse when a frame is aborted.

## Operation
- **Edge detection:** `ir_q` is `i_ir` registered. An edge exists when `i_ir != ir_q`: a rise is `i_ir=1`, a fall is `i_ir=0`.
- **On every edge:** `i_count` at that cycle is the width of the level that just ended. The FSM acts on it, and `o_count_clear` pulses on the next cycle.
- **Window compares:** all windows are inclusive and unsigned, at N bits.
- **FSM states:** IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE.
  - IDLE, rise → LEAD_MARK. Falls in IDLE are ignored, but they still clear the count.
  - LEAD_MARK, fall in the lead-mark window → LEAD_SPACE; otherwise abort.
  - LEAD_SPACE, rise in the lead-space window → BIT_MARK with `bit_cnt`=0; otherwise abort.
  - BIT_MARK, fall in the bit-mark window:
    - `bit_cnt`<32 → BIT_SPACE.
    - `bit_cnt`=32 → frame check, then IDLE.
    - Width outside the window → abort.
  - BIT_SPACE, rise: ZERO window shifts in 0, ONE window shifts in 1; `bit_cnt`++ → BIT_MARK. Any other width → abort.
- **Shift register:** 32-bit, LSB-first. Each new bit enters at bit 31 and the register shifts right. After 32 bits: [7:0]=addr, [15:8]=~addr, [23:16]=cmd, [31:24]=~cmd.
- **Frame check:** both complement fields must match. Pass: load `o_addr`/`o_cmd` and pulse `o_valid`. Fail: pulse `o_error` only.
- **Abort:** pulse `o_error`, go to IDLE, leave `o_addr`/`o_cmd` unchanged.
- **Timeout:** in any non-IDLE state, with no edge this cycle and `i_count >= TIMEOUT`, abort. If an edge and a timeout coincide, the edge wins.
- **Repeat codes:** the NEC repeat code (2.25 ms leader space) falls outside the lead-space window and therefore aborts. This is intentional.

## Timing
- **Reset values:** state IDLE; `ir_q`=0; shift register, `bit_cnt`, `o_addr` and `o_cmd` all 0; `o_count_clear`, `o_valid` and `o_error` all 0.
- **Registered outputs:** all outputs are registered. The `o_count_clear`, `o_valid` and `o_error` pulses are exactly 1 cycle, asserted the cycle after the triggering edge or timeout.
- **Valid and data timing:** `o_valid` is asserted in the same cycle `o_addr`/`o_cmd` take their new values.
- **Clear lag:** `o_count_clear` reaches the counter through `sync_counter`'s synchronizer. Integration guarantees this lag is less than one tick; the window margins absorb it.
- **Mid-frame reset:** a reset mid-frame drops the partial frame with no strobe.

## Structure
- **Package `ir_pkg`:** state enum `ir_state_t`, the default window constants, and `NEC_BITS`=32.
- **Sub-module `ir_edge_detect`:** holds the `ir_q` register and produces the rise/fall strobes.
- **Main module:** holds the FSM, the window compares, the shift register and the frame check.

## Test plan
- **Good frame:** addr 0x5A, cmd 0x0C with nominal widths (32/16 leader, 2/2 or 2/6 bits, stop mark 2) → `o_valid` once, `o_addr`=0x5A, `o_cmd`=0x0C, `o_error` never asserted.
- **Bad complement:** same frame but the ~cmd field is 0x00 → `o_error` once, `o_valid` never, outputs keep their prior values.
- **Leader too short:** leader mark of 20 ticks → `o_error` on the fall, FSM in IDLE; a following good frame still decodes.
- **Timeout:** IR stuck at space after bit 10 → `o_error` the cycle after `i_count` reaches 40.
- **Clear pulses:** every edge produces exactly one `o_count_clear` pulse, 1 cycle wide, one cycle after the edge. Window boundaries 5 and 7 decode as 1; widths 4 and 8 abort.
- **Mid-frame reset:** `i_reset` pulsed mid-frame → all outputs 0 immediately, no strobes; the next frame decodes normally.
